// File: rtl/dwa_element_selector_if.sv
// Handshake and data bundle between the notch-filter output, the DWA element
// selector and the unit-element switch block. The slave modport is the
// selector's view of the bundle and the master modport is its environment's view.
interface dwa_element_selector_if #(
    parameter int WIDTH  = 16,
    parameter int N_ELEM = 16
);
    localparam int LEVEL_BITS = $clog2(N_ELEM + 1);
    localparam int PTR_BITS   = $clog2(N_ELEM);

    logic [4*WIDTH-1:0]    sample_i;
    logic                  valid_i;
    logic                  ready_o;
    logic                  dem_en_i;
    logic [N_ELEM-1:0]     elem_en_o;
    logic [LEVEL_BITS-1:0] level_o;
    logic                  sat_o;
    logic [PTR_BITS-1:0]   ptr_o;
    logic                  valid_o;
    logic                  ready_i;

    modport slave (
        input  sample_i, valid_i, dem_en_i, ready_i,
        output ready_o, elem_en_o, level_o, sat_o, ptr_o, valid_o
    );

    modport master (
        output sample_i, valid_i, dem_en_i, ready_i,
        input  ready_o, elem_en_o, level_o, sat_o, ptr_o, valid_o
    );
endinterface

// File: rtl/dwa_element_selector.sv
// DWA unit-element selector. This block quantizes the wide signed filter
// sample to a level in the range 0..N_ELEM. It then drives that many unit
// elements. In DWA mode the enabled elements start at a rotating pointer, and
// in static mode they form a thermometer code. The block has two pipeline
// stages, and backpressure stalls the whole pipe.
module dwa_element_selector #(
    parameter int WIDTH  = 16,
    parameter int N_ELEM = 16,
    parameter int SHIFT  = 12
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    dwa_element_selector_if.slave    bus
);
    localparam int LEVEL_BITS = $clog2(N_ELEM + 1);
    localparam int PTR_BITS   = $clog2(N_ELEM);
    localparam int SW         = 4 * WIDTH;
    localparam int EW         = SW + 1;
    localparam logic signed [EW-1:0] HALF_S = EW'(N_ELEM / 2);
    localparam logic signed [EW-1:0] FULL_S = EW'(N_ELEM);

    // Thermometer code: the lowest lvl bits are set.
    function automatic logic [N_ELEM-1:0] thermo_code(input logic [LEVEL_BITS-1:0] lvl);
        logic [N_ELEM-1:0] t;
        t = '0;
        for (int k = 0; k < N_ELEM; k++) begin
            t[k] = (k < int'(lvl));
        end
        return t;
    endfunction

    // Rotate left by p. The index wraps for free because N_ELEM is a power of two.
    function automatic logic [N_ELEM-1:0] rotl(input logic [N_ELEM-1:0] t,
                                               input logic [PTR_BITS-1:0] p);
        logic [N_ELEM-1:0]   r;
        logic [PTR_BITS-1:0] idx;
        r = '0;
        for (int k = 0; k < N_ELEM; k++) begin
            idx    = PTR_BITS'(k) + p;
            r[idx] = t[k];
        end
        return r;
    endfunction

    logic signed [EW-1:0]  w_ext;
    logic signed [EW-1:0]  w_q;
    logic signed [EW-1:0]  w_off;
    logic [LEVEL_BITS-1:0] w_lvl;
    logic                  w_sat;
    logic                  w_stall;
    logic [N_ELEM-1:0]     w_en_nxt;
    logic [PTR_BITS-1:0]   w_ptr_nxt;

    logic                  r_v1;
    logic [LEVEL_BITS-1:0] r_lvl1;
    logic                  r_sat1;
    logic                  r_valid;
    logic [N_ELEM-1:0]     r_en;
    logic [LEVEL_BITS-1:0] r_lvl;
    logic                  r_sat;
    logic [PTR_BITS-1:0]   r_ptr;

    // Sign-extend by one bit so that adding the offset cannot overflow.
    assign w_ext   = $signed({bus.sample_i[SW-1], bus.sample_i});
    assign w_q     = w_ext >>> SHIFT;
    assign w_off   = w_q + HALF_S;
    assign w_stall = r_valid & ~bus.ready_i;

    // Clip the offset level into 0..N_ELEM and flag any clipping.
    always_comb begin
        w_lvl = '0;
        w_sat = 1'b0;
        if (w_off[EW-1]) begin
            w_lvl = '0;
            w_sat = 1'b1;
        end else if (w_off > FULL_S) begin
            w_lvl = LEVEL_BITS'(N_ELEM);
            w_sat = 1'b1;
        end else begin
            w_lvl = w_off[LEVEL_BITS-1:0];
            w_sat = 1'b0;
        end
    end

    // Choose the element pattern and the next pointer for the sample that enters stage 2.
    always_comb begin
        w_en_nxt  = '0;
        w_ptr_nxt = r_ptr;
        if (bus.dem_en_i) begin
            w_en_nxt = rotl(thermo_code(r_lvl1), r_ptr);
            if (r_v1) begin
                w_ptr_nxt = r_ptr + r_lvl1[PTR_BITS-1:0];
            end else begin
                w_ptr_nxt = r_ptr;
            end
        end else begin
            w_en_nxt  = thermo_code(r_lvl1);
            w_ptr_nxt = r_ptr;
        end
    end

    // Pipeline registers: both stages advance together unless the output is stalled.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_v1    <= 1'b0;
            r_lvl1  <= '0;
            r_sat1  <= 1'b0;
            r_valid <= 1'b0;
            r_en    <= '0;
            r_lvl   <= '0;
            r_sat   <= 1'b0;
            r_ptr   <= '0;
        end else if (!w_stall) begin
            r_v1    <= bus.valid_i;
            r_lvl1  <= w_lvl;
            r_sat1  <= w_sat;
            r_valid <= r_v1;
            r_ptr   <= w_ptr_nxt;
            if (r_v1) begin
                r_en  <= w_en_nxt;
                r_lvl <= r_lvl1;
                r_sat <= r_sat1;
            end else begin
                r_en  <= '0;
                r_lvl <= '0;
                r_sat <= 1'b0;
            end
        end
    end

    assign bus.ready_o   = ~w_stall;
    assign bus.valid_o   = r_valid;
    assign bus.elem_en_o = r_en;
    assign bus.level_o   = r_lvl;
    assign bus.sat_o     = r_sat;
    assign bus.ptr_o     = r_ptr;
endmodule
